conv3x3_sched: RTL and testbench
================================

Name: conv3x3_sched

Overview:
- Sequencer for the 3x3 convolution datapath (conv + cal_addtree_int16_x9).
- Holds the nine-tap weight register file and walks a valid-mode (no padding) 3x3 window across an IFM stored in M10K.
- Fetches each window pixel-by-pixel into a 72-bit window register, waits out the adder-tree latency, then writes each result to the OFM M10K in raster order.
- Sits between the M10K buffers and the conv instance; started by the top-level control logic.

Parameters:
IMG_W, 32, IFM width in pixels (>=3)
IMG_H, 32, IFM height in pixels (>=3)
ADDR_W, 10, IFM address width (2**ADDR_W >= IMG_W*IMG_H)
OADDR_W, 10, OFM address width (2**OADDR_W >= (IMG_W-2)*(IMG_H-2))
RD_LAT, 1, IFM M10K read latency in cycles (>=1)
TREE_LAT, 2, cycles from stable window to valid ofm_stream (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a full-image pass when idle
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the final OFM write
wt_we  in  1  weight write strobe
wt_idx  in  4  tap index 0..8 (k = row*3 + col)
wt_data  in  8  signed weight value
ifm_rd_en  out  1  IFM read request
ifm_rd_addr  out  ADDR_W  IFM read address
ifm_rd_data  in  8  unsigned pixel, valid RD_LAT cycles after the request
ifm_win3x3  out  72  window to conv, tap k in bits [8k+7:8k]
weight_win3x3  out  72  weights to conv, same packing
ofm_stream  in  18  signed result from conv
ofm_we  out  1  OFM write strobe
ofm_addr  out  OADDR_W  OFM write address
ofm_data  out  18  signed result written

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy, done, ifm_rd_en, ofm_we all 0.
  - ifm_rd_addr, ofm_addr, ofm_data, window register and all nine weights 0.
  - Reset mid-pass abandons the pass; no further writes occur.
- Weight load: in IDLE, wt_we=1 with wt_idx<=8 writes wt_data to tap wt_idx on the next edge.
  - Ignored when wt_idx>8 or when busy.
  - weight_win3x3 is driven continuously from the register file.
- Start: accepted only in IDLE. start while busy is ignored. On acceptance: x=0, y=0, state FETCH.
- FETCH (9 cycles, k=0..8):
  - ifm_rd_en=1.
  - ifm_rd_addr = (y+k/3)*IMG_W + x + k%3.
  - A k-index shift pipe of depth RD_LAT tags each returning byte; ifm_rd_data is captured into window slot k RD_LAT cycles after its request.
- WAIT_RD (RD_LAT cycles): ifm_rd_en=0; remaining captures complete. Window is then stable and held unchanged until the next FETCH.
- WAIT_TREE (TREE_LAT cycles): counter only.
- WRITE (1 cycle):
  - ofm_we=1, ofm_data=ofm_stream, ofm_addr = y*(IMG_W-2)+x.
  - Advance x. On x = IMG_W-3, wrap x to 0 and increment y.
  - If (x,y) was (IMG_W-3, IMG_H-3), go to DONE; else go to FETCH.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Timing:
  - Cycles per output: 9 + RD_LAT + TREE_LAT + 1 (13 at defaults).
  - busy high for (IMG_W-2)*(IMG_H-2)*(that) cycles.
- ofm_we, ifm_rd_en and done are registered outputs and are never high in the same cycle as each other.
- No arithmetic is performed here. ofm_data is a bit-exact copy of ofm_stream, 18-bit two's complement.

Decomposition:
- Shared package conv_pkg:
  - PIX_W=8, WT_W=8, ACC_W=18, N_TAPS=9.
  - State encoding: IDLE, FETCH, WAIT_RD, WAIT_TREE, WRITE, DONE.
  - Tap-index-to-bit-slice helper constant.
- One sub-module, conv_win_fetch: address generation for the nine taps, the RD_LAT tag pipe, and the window register. Top-level conv3x3_sched keeps the FSM, x/y counters, weight file and OFM write port.

Test Plan:
- IMG_W=IMG_H=4, pixel[i]=i, all weights 1, real conv/addtree model -> OFM[0..3] = 45, 54, 81, 90; busy 52 cycles; single done pulse.
- Centre weight 0xFF (-1), others 0, pixel at (1,1)=200 -> OFM[0] = -200 (18'h3FF38).
- start pulsed again while busy, and wt_we while busy -> ignored; outputs match the unperturbed run; weights unchanged.
- wt_idx=9..15 writes in IDLE -> weight_win3x3 unchanged.
- rst_n low during pass 2's FETCH -> all outputs 0 immediately; no ofm_we after; a fresh start then produces a correct full pass.
- RD_LAT=2, TREE_LAT=3 -> 15 cycles per output, identical OFM contents to the defaults.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and tap helpers for the 3x3 convolution sequencer.
package conv_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WT_W   = 8;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned N_TAPS = 9;
    localparam int unsigned TAP_W  = 4;
    localparam int unsigned WIN_W  = N_TAPS * PIX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RD,
        ST_WAIT_TREE,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Tag travelling alongside each outstanding IFM read.
    typedef struct packed {
        logic             vld;
        logic [TAP_W-1:0] tap;
    } rd_tag_t;

    // Tap k occupies bits [tap_lsb(k) +: 8] of a window word.
    function automatic int unsigned tap_lsb(input int unsigned k);
        return k * PIX_W;
    endfunction

    function automatic int unsigned tap_row(input int unsigned k);
        return k / 3;
    endfunction

    function automatic int unsigned tap_col(input int unsigned k);
        return k % 3;
    endfunction

endpackage

// File: rtl/conv_win_fetch.sv
// IFM tap address generation, read-tag pipe and the 72-bit window register.
module conv_win_fetch
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned X_W    = 5,
    parameter int unsigned Y_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_nxt,
    input  logic [TAP_W-1:0]  tap_nxt,
    input  logic [X_W-1:0]    x_nxt,
    input  logic [Y_W-1:0]    y_nxt,
    output logic              ifm_rd_en,
    output logic [ADDR_W-1:0] ifm_rd_addr,
    input  logic [PIX_W-1:0]  ifm_rd_data,
    output logic [WIN_W-1:0]  ifm_win3x3
);

    localparam int unsigned LAST = RD_LAT - 1;

    logic [ADDR_W-1:0] addr_c;
    logic [TAP_W-1:0]  rd_tap;
    rd_tag_t           tag_q [RD_LAT];
    rd_tag_t           tag_last;

    always_comb begin
        addr_c = ADDR_W'((32'(y_nxt) + tap_row(32'(tap_nxt))) * IMG_W
                         + 32'(x_nxt) + tap_col(32'(tap_nxt)));
    end

    // Request register: address/tap only move when a new read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_rd_en   <= 1'b0;
            ifm_rd_addr <= '0;
            rd_tap      <= '0;
        end else begin
            ifm_rd_en <= req_nxt;
            if (req_nxt) begin
                ifm_rd_addr <= addr_c;
                rd_tap      <= tap_nxt;
            end
        end
    end

    // Tag pipe: the entry leaving the last stage matches the byte on ifm_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: ifm_rd_en, tap: rd_tap};
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_last = tag_q[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_win3x3 <= '0;
        end else if (tag_last.vld) begin
            for (int k = 0; k < int'(N_TAPS); k++) begin
                if (tag_last.tap == TAP_W'(k)) begin
                    ifm_win3x3[tap_lsb(k) +: PIX_W] <= ifm_rd_data;
                end
            end
        end
    end

endmodule

// File: rtl/conv3x3_sched.sv
// Sequencer for the 3x3 conv datapath: weight file, window walk and OFM write-back.
module conv3x3_sched
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W    = 32,
    parameter int unsigned IMG_H    = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned OADDR_W  = 10,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned TREE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               wt_we,
    input  logic [TAP_W-1:0]   wt_idx,
    input  logic [WT_W-1:0]    wt_data,
    output logic               ifm_rd_en,
    output logic [ADDR_W-1:0]  ifm_rd_addr,
    input  logic [PIX_W-1:0]   ifm_rd_data,
    output logic [WIN_W-1:0]   ifm_win3x3,
    output logic [WIN_W-1:0]   weight_win3x3,
    input  logic [ACC_W-1:0]   ofm_stream,
    output logic               ofm_we,
    output logic [OADDR_W-1:0] ofm_addr,
    output logic [ACC_W-1:0]   ofm_data
);

    localparam int unsigned X_W   = $clog2(IMG_W);
    localparam int unsigned Y_W   = $clog2(IMG_H);
    localparam int unsigned CNT_W = $clog2(N_TAPS + RD_LAT + TREE_LAT + 1);

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [X_W-1:0]     x_q, x_nxt;
    logic [Y_W-1:0]     y_q, y_nxt;
    logic               req_nxt;
    logic [TAP_W-1:0]   tap_nxt;
    logic               busy_nxt, done_nxt, ofm_we_nxt;
    logic [OADDR_W-1:0] ofm_addr_nxt;
    logic [ACC_W-1:0]   ofm_data_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ofm_we   <= 1'b0;
            ofm_addr <= '0;
            ofm_data <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            ofm_we   <= ofm_we_nxt;
            ofm_addr <= ofm_addr_nxt;
            ofm_data <= ofm_data_nxt;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        x_nxt        = x_q;
        y_nxt        = y_q;
        req_nxt      = 1'b0;
        tap_nxt      = '0;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        ofm_we_nxt   = 1'b0;
        ofm_addr_nxt = ofm_addr;
        ofm_data_nxt = ofm_data;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    cnt_nxt   = '0;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    busy_nxt  = 1'b1;
                    req_nxt   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (cnt_q == CNT_W'(N_TAPS - 1)) begin
                    state_nxt = ST_WAIT_RD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                    req_nxt = 1'b1;
                    tap_nxt = TAP_W'(cnt_q) + TAP_W'(1);
                end
            end
            ST_WAIT_RD: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    state_nxt = ST_WAIT_TREE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_TREE: begin
                if (cnt_q == CNT_W'(TREE_LAT - 1)) begin
                    state_nxt    = ST_WRITE;
                    cnt_nxt      = '0;
                    ofm_we_nxt   = 1'b1;
                    ofm_data_nxt = ofm_stream;
                    ofm_addr_nxt = OADDR_W'(32'(y_q) * (IMG_W - 2) + 32'(x_q));
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                state_nxt = ST_FETCH;
                cnt_nxt   = '0;
                req_nxt   = 1'b1;
                if (x_q == X_W'(IMG_W - 3)) begin
                    x_nxt = '0;
                    if (y_q == Y_W'(IMG_H - 3)) begin
                        state_nxt = ST_DONE;
                        req_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        y_nxt = y_q + Y_W'(1);
                    end
                end else begin
                    x_nxt = x_q + X_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Weight file only accepts writes while idle; out-of-range indices match no tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_win3x3 <= '0;
        end else if (state_q == ST_IDLE && wt_we) begin
            for (int k = 0; k < int'(N_TAPS); k++) begin
                if (wt_idx == TAP_W'(k)) begin
                    weight_win3x3[tap_lsb(k) +: WT_W] <= wt_data;
                end
            end
        end
    end

    conv_win_fetch #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_fetch (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_nxt     (req_nxt),
        .tap_nxt     (tap_nxt),
        .x_nxt       (x_nxt),
        .y_nxt       (y_nxt),
        .ifm_rd_en   (ifm_rd_en),
        .ifm_rd_addr (ifm_rd_addr),
        .ifm_rd_data (ifm_rd_data),
        .ifm_win3x3  (ifm_win3x3)
    );

endmodule

// File: tb/tb_conv3x3_sched.sv
// Bench for conv3x3_sched: two instances (default latencies and RD_LAT=2/TREE_LAT=3) on a 4x4 image.
module tb_conv3x3_sched;

    localparam int IMG  = 4;
    localparam int NOUT = (IMG - 2) * (IMG - 2);
    localparam int RD0  = 1;
    localparam int TR0  = 2;
    localparam int RD1  = 2;
    localparam int TR1  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wt_we = 1'b0;
    logic [3:0]  wt_idx = '0;
    logic [7:0]  wt_data = '0;

    logic        busy0, done0, rd_en0, ofm_we0;
    logic        busy1, done1, rd_en1, ofm_we1;
    logic [9:0]  rd_addr0, rd_addr1, ofm_addr0, ofm_addr1;
    logic [7:0]  rd_data0, rd_data1, rd_d1a;
    logic [71:0] win0, win1, wwin0, wwin1;
    logic [71:0] wp0, wp1a, wp1b;
    logic [17:0] stream0, stream1, ofm_data0, ofm_data1;

    int checks = 0;
    int errors = 0;
    int wt_model [9];
    int pix_model [IMG*IMG];
    logic [7:0] ifm_mem [1024];

    int busy_cnt [2];
    int done_cnt [2];
    int wr_cnt [2];
    int clash_cnt [2];
    int bad_addr [2];
    logic [17:0] ofm_got [2][NOUT];
    int exp_busy [2] = '{NOUT * (10 + RD0 + TR0), NOUT * (10 + RD1 + TR1)};

    always #5 clk = ~clk;

    conv3x3_sched #(.IMG_W(IMG), .IMG_H(IMG), .ADDR_W(10), .OADDR_W(10),
                    .RD_LAT(RD0), .TREE_LAT(TR0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
        .wt_we(wt_we), .wt_idx(wt_idx), .wt_data(wt_data),
        .ifm_rd_en(rd_en0), .ifm_rd_addr(rd_addr0), .ifm_rd_data(rd_data0),
        .ifm_win3x3(win0), .weight_win3x3(wwin0), .ofm_stream(stream0),
        .ofm_we(ofm_we0), .ofm_addr(ofm_addr0), .ofm_data(ofm_data0));

    conv3x3_sched #(.IMG_W(IMG), .IMG_H(IMG), .ADDR_W(10), .OADDR_W(10),
                    .RD_LAT(RD1), .TREE_LAT(TR1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
        .wt_we(wt_we), .wt_idx(wt_idx), .wt_data(wt_data),
        .ifm_rd_en(rd_en1), .ifm_rd_addr(rd_addr1), .ifm_rd_data(rd_data1),
        .ifm_win3x3(win1), .weight_win3x3(wwin1), .ofm_stream(stream1),
        .ofm_we(ofm_we1), .ofm_addr(ofm_addr1), .ofm_data(ofm_data1));

    // M10K read ports with 1- and 2-cycle latency.
    always @(posedge clk) begin
        rd_data0 <= ifm_mem[rd_addr0];
        rd_d1a   <= ifm_mem[rd_addr1];
        rd_data1 <= rd_d1a;
    end

    // Conv + adder tree: result reflects a window held for TREE_LAT cycles.
    function automatic logic [17:0] conv_dot(input logic [71:0] px, input logic [71:0] wt);
        int acc = 0;
        for (int k = 0; k < 9; k++) begin
            acc += int'(px[k*8 +: 8]) * int'($signed(wt[k*8 +: 8]));
        end
        return 18'(acc);
    endfunction

    always @(posedge clk) begin
        wp0  <= win0;
        wp1a <= win1;
        wp1b <= wp1a;
    end
    assign stream0 = conv_dot(wp0, wwin0);
    assign stream1 = conv_dot(wp1b, wwin1);

    // Golden valid-mode convolution straight from the image and weight arrays.
    function automatic logic [17:0] ref_ofm(input int o);
        int acc = 0;
        int ox = o % (IMG - 2);
        int oy = o / (IMG - 2);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc += pix_model[(oy + r) * IMG + ox + c] * wt_model[r * 3 + c];
            end
        end
        return 18'(acc);
    endfunction

    function automatic logic [71:0] pack_wt();
        logic [71:0] p = '0;
        for (int k = 0; k < 9; k++) begin
            p[k*8 +: 8] = 8'(wt_model[k]);
        end
        return p;
    endfunction

    task automatic mon(input int i, input logic b, input logic d, input logic r, input logic w,
                       input logic [9:0] a, input logic [17:0] dat);
        if (b) busy_cnt[i]++;
        if (d) done_cnt[i]++;
        if (int'(r) + int'(w) + int'(d) > 1) clash_cnt[i]++;
        if (w) begin
            wr_cnt[i]++;
            if (a < 10'(NOUT)) ofm_got[i][a[1:0]] = dat;
            else bad_addr[i]++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, busy0, done0, rd_en0, ofm_we0, ofm_addr0, ofm_data0);
            mon(1, busy1, done1, rd_en1, ofm_we1, ofm_addr1, ofm_data1);
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0; done_cnt[i] = 0; wr_cnt[i] = 0;
            clash_cnt[i] = 0; bad_addr[i] = 0;
            for (int o = 0; o < NOUT; o++) ofm_got[i][o] = 'x;
        end
    endtask

    task automatic rand_image();
        for (int p = 0; p < IMG*IMG; p++) begin
            pix_model[p] = int'($urandom_range(0, 255));
            ifm_mem[p]   = 8'(pix_model[p]);
        end
    endtask

    task automatic rand_weights();
        for (int k = 0; k < 9; k++) wt_model[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic load_weights();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            wt_we = 1'b1; wt_idx = 4'(k); wt_data = 8'(wt_model[k]);
        end
        @(negedge clk);
        wt_we = 1'b0;
    endtask

    task automatic run_pass(input bit perturb, output bit timed_out);
        #1 clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); #1;
            if (perturb && (c == 10 || c == 30)) begin
                start = 1'b1; wt_we = 1'b1;
                wt_idx = 4'($urandom_range(0, 8)); wt_data = 8'($urandom);
            end else begin
                start = 1'b0; wt_we = 1'b0;
            end
            if (done_cnt[0] >= 1 && done_cnt[1] >= 1) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0; wt_we = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_pass(input string name, input bit timed_out);
        logic [17:0] exp;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s timeout: done not seen within 400 cycles", name);
        end
        for (int i = 0; i < 2; i++) begin
            for (int o = 0; o < NOUT; o++) begin
                exp = ref_ofm(o);
                checks++;
                if (ofm_got[i][o] !== exp) begin
                    errors++;
                    $display("FAIL %s inst%0d ofm[%0d]: got %h expected %h", name, i, o, ofm_got[i][o], exp);
                end
            end
            checks++;
            if (busy_cnt[i] !== exp_busy[i]) begin
                errors++;
                $display("FAIL %s inst%0d busy cycles: got %0d expected %0d", name, i, busy_cnt[i], exp_busy[i]);
            end
            checks++;
            if (done_cnt[i] !== 1) begin
                errors++;
                $display("FAIL %s inst%0d done pulses: got %0d expected 1", name, i, done_cnt[i]);
            end
            checks++;
            if (wr_cnt[i] !== NOUT || bad_addr[i] !== 0 || clash_cnt[i] !== 0) begin
                errors++;
                $display("FAIL %s inst%0d writes/badaddr/overlap: got %0d/%0d/%0d expected %0d/0/0",
                         name, i, wr_cnt[i], bad_addr[i], clash_cnt[i], NOUT);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if ({busy0, done0, rd_en0, ofm_we0, rd_addr0, ofm_addr0, ofm_data0, win0, wwin0} !== '0) begin
                errors++;
                $display("FAIL reset inst0 phase%0d: got %h expected 0", pass,
                         {busy0, done0, rd_en0, ofm_we0, rd_addr0, ofm_addr0, ofm_data0, win0, wwin0});
            end
            checks++;
            if ({busy1, done1, rd_en1, ofm_we1, rd_addr1, ofm_addr1, ofm_data1, win1, wwin1} !== '0) begin
                errors++;
                $display("FAIL reset inst1 phase%0d: got %h expected 0", pass,
                         {busy1, done1, rd_en1, ofm_we1, rd_addr1, ofm_addr1, ofm_data1, win1, wwin1});
            end
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_spec_vector();
        bit to;
        int spec_exp [NOUT] = '{45, 54, 81, 90};
        for (int p = 0; p < IMG*IMG; p++) begin
            pix_model[p] = p; ifm_mem[p] = 8'(p);
        end
        for (int k = 0; k < 9; k++) wt_model[k] = 1;
        load_weights();
        run_pass(1'b0, to);
        check_pass("ramp_ones", to);
        for (int o = 0; o < NOUT; o++) begin
            checks++;
            if (ofm_got[0][o] !== 18'(spec_exp[o]) || ofm_got[1][o] !== 18'(spec_exp[o])) begin
                errors++;
                $display("FAIL ramp_const ofm[%0d]: got %0d/%0d expected %0d", o,
                         ofm_got[0][o], ofm_got[1][o], spec_exp[o]);
            end
        end
    endtask

    task automatic test_neg_centre();
        bit to;
        for (int p = 0; p < IMG*IMG; p++) begin
            pix_model[p] = (p == IMG + 1) ? 200 : 0;
            ifm_mem[p]   = 8'(pix_model[p]);
        end
        for (int k = 0; k < 9; k++) wt_model[k] = (k == 4) ? -1 : 0;
        load_weights();
        run_pass(1'b0, to);
        check_pass("neg_centre", to);
        checks++;
        if (ofm_got[0][0] !== 18'h3FF38 || ofm_got[1][0] !== 18'h3FF38) begin
            errors++;
            $display("FAIL neg_centre_const: got %h/%h expected 3ff38", ofm_got[0][0], ofm_got[1][0]);
        end
    endtask

    task automatic test_random();
        bit to;
        for (int n = 0; n < 3; n++) begin
            rand_image();
            rand_weights();
            load_weights();
            run_pass(1'b0, to);
            check_pass("random", to);
        end
    endtask

    task automatic test_bad_idx();
        for (int idx = 9; idx < 16; idx++) begin
            @(negedge clk);
            wt_we = 1'b1; wt_idx = 4'(idx); wt_data = 8'($urandom);
        end
        @(negedge clk);
        wt_we = 1'b0;
        @(negedge clk);
        checks++;
        if (wwin0 !== pack_wt() || wwin1 !== pack_wt()) begin
            errors++;
            $display("FAIL bad_idx weights: got %h/%h expected %h", wwin0, wwin1, pack_wt());
        end
    endtask

    task automatic test_busy_ignore();
        bit to;
        rand_image();
        rand_weights();
        load_weights();
        run_pass(1'b1, to);
        check_pass("busy_ignore", to);
        checks++;
        if (wwin0 !== pack_wt() || wwin1 !== pack_wt()) begin
            errors++;
            $display("FAIL busy_ignore weights: got %h/%h expected %h", wwin0, wwin1, pack_wt());
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit found = 1'b0;
        rand_image();
        rand_weights();
        load_weights();
        #1 clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (wr_cnt[0] >= 1 && rd_en0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid: second fetch not seen, wr_cnt %0d expected >=1", wr_cnt[0]);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, rd_en0, ofm_we0, rd_addr0, ofm_addr0, ofm_data0, win0, wwin0,
             busy1, done1, rd_en1, ofm_we1, rd_addr1, ofm_addr1, ofm_data1, win1, wwin1} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %h/%h expected 0",
                     {busy0, done0, rd_en0, ofm_we0, rd_addr0, ofm_addr0, ofm_data0, win0, wwin0},
                     {busy1, done1, rd_en1, ofm_we1, rd_addr1, ofm_addr1, ofm_data1, win1, wwin1});
        end
        clear_mon();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (wr_cnt[0] !== 0 || wr_cnt[1] !== 0 || busy_cnt[0] !== 0 || busy_cnt[1] !== 0) begin
            errors++;
            $display("FAIL reset_mid activity after reset: writes %0d/%0d busy %0d/%0d expected 0",
                     wr_cnt[0], wr_cnt[1], busy_cnt[0], busy_cnt[1]);
        end
        rand_weights();
        load_weights();
        run_pass(1'b0, to);
        check_pass("after_reset", to);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) ifm_mem[a] = '0;
        for (int k = 0; k < 9; k++) wt_model[k] = 0;
        clear_mon();
        test_reset();
        test_spec_vector();
        test_neg_centre();
        test_random();
        test_bad_idx();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
